// File: rtl/link_endpoint.sv
// Network endpoint: whole-packet FIFO plus flit serialiser towards the router,
// flit deserialiser plus packet FIFO towards the host-side take interface.
module link_endpoint #(
  parameter int PKT_W     = 32,
  parameter int FLIT_W    = 8,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic [PKT_W-1:0]               pkt_in,
  input  logic                           pkt_in_avail,
  output logic                           cQ_full,
  output logic [$clog2(OUT_DEPTH+1)-1:0] out_count,
  input  logic                           free_outbound,
  output logic                           put_outbound,
  output logic [FLIT_W-1:0]              payload_outbound,
  output logic                           free_inbound,
  input  logic                           put_inbound,
  input  logic [FLIT_W-1:0]              payload_inbound,
  output logic [PKT_W-1:0]               pkt_out,
  output logic                           pkt_out_avail,
  input  logic                           pkt_out_take,
  output logic [$clog2(IN_DEPTH+1)-1:0]  in_count,
  output logic                           proto_err
);
  localparam int NFLIT = PKT_W / FLIT_W;
  localparam int OCW   = $clog2(OUT_DEPTH + 1);
  localparam int ICW   = $clog2(IN_DEPTH + 1);
  localparam int OPW   = $clog2(OUT_DEPTH);
  localparam int IPW   = $clog2(IN_DEPTH);
  localparam int XW    = $clog2(NFLIT);
  localparam int SH_W  = PKT_W - FLIT_W;

  localparam logic [XW-1:0]  LAST_FLIT = XW'(NFLIT - 1);
  localparam logic [XW-1:0]  ONE_FLIT  = XW'(1);
  localparam logic [OPW-1:0] OUT_LAST  = OPW'(OUT_DEPTH - 1);
  localparam logic [IPW-1:0] IN_LAST   = IPW'(IN_DEPTH - 1);
  localparam logic [OCW-1:0] OUT_FULL  = OCW'(OUT_DEPTH);
  localparam logic [ICW-1:0] IN_FULL   = ICW'(IN_DEPTH);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_e;

  logic [PKT_W-1:0] out_mem_q [OUT_DEPTH];
  logic [OPW-1:0]   out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OCW-1:0]   out_cnt_q, out_cnt_d;
  logic             out_full, out_push, out_pop;

  logic [PKT_W-1:0] in_mem_q [IN_DEPTH];
  logic [IPW-1:0]   in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [ICW-1:0]   in_cnt_q, in_cnt_d;
  logic             in_full, in_push, in_pop, in_wr_en;

  tx_state_e        tx_state_q, tx_state_d;
  logic [XW-1:0]    tidx_q, tidx_d;
  logic [PKT_W-1:0] tx_head_shift;

  rx_state_e        rx_state_q, rx_state_d;
  logic [XW-1:0]    ridx_q, ridx_d;
  logic [SH_W-1:0]  rx_shift_q, rx_shift_d;
  logic             err_q, err_d;

  assign out_full = (out_cnt_q == OUT_FULL);
  assign out_push = pkt_in_avail && !out_full;
  assign in_full  = (in_cnt_q == IN_FULL);
  assign in_pop   = pkt_out_take && (in_cnt_q != '0);
  assign in_wr_en = in_push && !in_full;

  always_comb begin
    tx_state_d = tx_state_q;
    tidx_d     = tidx_q;
    out_pop    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if ((out_cnt_q != '0) && free_outbound) begin
          tx_state_d = TX_SEND;
          tidx_d     = '0;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_SEND: begin
        if (tidx_q == LAST_FLIT) begin
          out_pop    = 1'b1;
          tx_state_d = TX_IDLE;
          tidx_d     = '0;
        end else begin
          tidx_d = tidx_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tidx_d     = '0;
      end
    endcase
  end

  // Shift the head packet so the current flit sits in the top FLIT_W bits.
  assign tx_head_shift    = out_mem_q[out_rd_q] << (tidx_q * FLIT_W);
  assign put_outbound     = (tx_state_q == TX_SEND);
  assign payload_outbound = put_outbound ? tx_head_shift[PKT_W-1 -: FLIT_W] : '0;

  always_comb begin
    rx_state_d = rx_state_q;
    ridx_d     = ridx_q;
    rx_shift_d = rx_shift_q;
    in_push    = 1'b0;
    err_d      = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (put_inbound && !in_full) begin
          rx_shift_d = SH_W'({rx_shift_q, payload_inbound});
          ridx_d     = ONE_FLIT;
          rx_state_d = RX_RECV;
        end else if (put_inbound) begin
          err_d = 1'b1;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_RECV: begin
        if (put_inbound && (ridx_q == LAST_FLIT)) begin
          in_push    = 1'b1;
          ridx_d     = '0;
          rx_state_d = RX_IDLE;
        end else if (put_inbound) begin
          rx_shift_d = SH_W'({rx_shift_q, payload_inbound});
          ridx_d     = ridx_q + 1'b1;
        end else begin
          err_d      = 1'b1;
          ridx_d     = '0;
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        ridx_d     = '0;
      end
    endcase
  end

  // Pointer wrap and occupancy; simultaneous push and pop leave the count unchanged.
  always_comb begin
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    in_wr_d   = in_wr_q;
    in_rd_d   = in_rd_q;
    if (out_push) out_wr_d = (out_wr_q == OUT_LAST) ? '0 : out_wr_q + 1'b1;
    else          out_wr_d = out_wr_q;
    if (out_pop)  out_rd_d = (out_rd_q == OUT_LAST) ? '0 : out_rd_q + 1'b1;
    else          out_rd_d = out_rd_q;
    if (in_wr_en) in_wr_d  = (in_wr_q == IN_LAST) ? '0 : in_wr_q + 1'b1;
    else          in_wr_d  = in_wr_q;
    if (in_pop)   in_rd_d  = (in_rd_q == IN_LAST) ? '0 : in_rd_q + 1'b1;
    else          in_rd_d  = in_rd_q;
    case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
    case ({in_wr_en, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + 1'b1;
      2'b01:   in_cnt_d = in_cnt_q - 1'b1;
      default: in_cnt_d = in_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      tx_state_q <= TX_IDLE;
      tidx_q     <= '0;
      rx_state_q <= RX_IDLE;
      ridx_q     <= '0;
      rx_shift_q <= '0;
      err_q      <= 1'b0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      out_cnt_q  <= '0;
      in_wr_q    <= '0;
      in_rd_q    <= '0;
      in_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tidx_q     <= tidx_d;
      rx_state_q <= rx_state_d;
      ridx_q     <= ridx_d;
      rx_shift_q <= rx_shift_d;
      err_q      <= err_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      out_cnt_q  <= out_cnt_d;
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      in_cnt_q   <= in_cnt_d;
    end
  end

  // Storage is not reset: occupancy counters alone decide what is valid.
  always_ff @(posedge clk) begin
    if (out_push) out_mem_q[out_wr_q] <= pkt_in;
    if (in_wr_en) in_mem_q[in_wr_q]   <= {rx_shift_q, payload_inbound};
  end

  assign cQ_full       = out_full;
  assign out_count     = out_cnt_q;
  assign in_count      = in_cnt_q;
  assign pkt_out_avail = (in_cnt_q != '0);
  assign pkt_out       = pkt_out_avail ? in_mem_q[in_rd_q] : '0;
  assign free_inbound  = (rx_state_q == RX_IDLE) && !in_full;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_link_endpoint.sv
// Scoreboard bench for link_endpoint: expected packets are queued when driven
// and compared when the endpoint emits them on either path.
`timescale 1ns/1ps
module tb_link_endpoint;
  localparam int PKT_W = 32;
  localparam int FLIT_W = 8;
  localparam int NFLIT = 4;

  logic              clk = 1'b0;
  logic              rst_b;
  logic [PKT_W-1:0]  pkt_in;
  logic              pkt_in_avail;
  logic              cQ_full;
  logic [2:0]        out_count;
  logic              free_outbound;
  logic              put_outbound;
  logic [FLIT_W-1:0] payload_outbound;
  logic              free_inbound;
  logic              put_inbound;
  logic [FLIT_W-1:0] payload_inbound;
  logic [PKT_W-1:0]  pkt_out;
  logic              pkt_out_avail;
  logic              pkt_out_take;
  logic [2:0]        in_count;
  logic              proto_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] tx_exp[$];
  logic [31:0] rx_exp[$];

  link_endpoint #(.PKT_W(32), .FLIT_W(8), .OUT_DEPTH(4), .IN_DEPTH(4)) dut (
    .clk(clk), .rst_b(rst_b), .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail),
    .cQ_full(cQ_full), .out_count(out_count), .free_outbound(free_outbound),
    .put_outbound(put_outbound), .payload_outbound(payload_outbound),
    .free_inbound(free_inbound), .put_inbound(put_inbound), .payload_inbound(payload_inbound),
    .pkt_out(pkt_out), .pkt_out_avail(pkt_out_avail), .pkt_out_take(pkt_out_take),
    .in_count(in_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a packet on the router side and assembles its flits.
  task automatic collect_tx(input int max_wait, output logic [31:0] pkt, output bit ok, output int start_cyc);
    int w;
    ok = 1'b1;
    pkt = '0;
    w = 0;
    while (put_outbound !== 1'b1 && w < max_wait) begin
      tick();
      w++;
    end
    start_cyc = cyc;
    if (put_outbound !== 1'b1) ok = 1'b0;
    else begin
      for (int k = 0; k < NFLIT; k++) begin
        if (put_outbound !== 1'b1) ok = 1'b0;
        pkt = {pkt[23:0], payload_outbound};
        if (k < NFLIT - 1) tick();
      end
    end
  endtask

  task automatic send_rx(input logic [31:0] p);
    for (int k = 0; k < NFLIT; k++) begin
      put_inbound = 1'b1;
      payload_inbound = p[31-8*k -: 8];
      tick();
    end
    put_inbound = 1'b0;
    payload_inbound = '0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
    n_checks++; if (put_outbound !== 1'b0) begin n_errors++; $display("FAIL rst_put_outbound: got %b want 0", put_outbound); end
    n_checks++; if (payload_outbound !== 8'h00) begin n_errors++; $display("FAIL rst_payload_outbound: got %h want 00", payload_outbound); end
    n_checks++; if (free_inbound !== 1'b1) begin n_errors++; $display("FAIL rst_free_inbound: got %b want 1", free_inbound); end
    n_checks++; if (cQ_full !== 1'b0) begin n_errors++; $display("FAIL rst_cQ_full: got %b want 0", cQ_full); end
    n_checks++; if (out_count !== 3'd0) begin n_errors++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
    n_checks++; if (pkt_out !== 32'h0) begin n_errors++; $display("FAIL rst_pkt_out: got %h want 0", pkt_out); end
    n_checks++; if (pkt_out_avail !== 1'b0) begin n_errors++; $display("FAIL rst_pkt_out_avail: got %b want 0", pkt_out_avail); end
    n_checks++; if (in_count !== 3'd0) begin n_errors++; $display("FAIL rst_in_count: got %0d want 0", in_count); end
    n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL rst_proto_err: got %b want 0", proto_err); end
  endtask

  task automatic test_tx_single();
    logic [31:0] exp;
    free_outbound = 1'b1;
    pkt_in = 32'hA5123456;
    pkt_in_avail = 1'b1;
    tx_exp.push_back(pkt_in);
    tick();
    pkt_in_avail = 1'b0;
    n_checks++; if (out_count !== 3'd1) begin n_errors++; $display("FAIL tx1_count_after_push: got %0d want 1", out_count); end
    n_checks++; if (put_outbound !== 1'b0) begin n_errors++; $display("FAIL tx1_put_early: got %b want 0", put_outbound); end
    tick();
    exp = tx_exp.pop_front();
    for (int k = 0; k < NFLIT; k++) begin
      n_checks++; if (put_outbound !== 1'b1) begin n_errors++; $display("FAIL tx1_put_flit%0d: got %b want 1", k, put_outbound); end
      n_checks++; if (payload_outbound !== exp[31-8*k -: 8]) begin n_errors++; $display("FAIL tx1_flit%0d: got %h want %h", k, payload_outbound, exp[31-8*k -: 8]); end
      n_checks++; if (out_count !== 3'd1) begin n_errors++; $display("FAIL tx1_count_during%0d: got %0d want 1", k, out_count); end
      tick();
    end
    n_checks++; if (put_outbound !== 1'b0) begin n_errors++; $display("FAIL tx1_put_end: got %b want 0", put_outbound); end
    n_checks++; if (payload_outbound !== 8'h00) begin n_errors++; $display("FAIL tx1_payload_end: got %h want 00", payload_outbound); end
    n_checks++; if (out_count !== 3'd0) begin n_errors++; $display("FAIL tx1_count_end: got %0d want 0", out_count); end
  endtask

  task automatic test_tx_fill_drop();
    logic [31:0] exp, got;
    bit ok;
    int st, prev;
    free_outbound = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pkt_in = 32'hC0DE0000 | 32'(i * 17 + 1);
      pkt_in_avail = 1'b1;
      if (i < 4) tx_exp.push_back(pkt_in);
      tick();
      if (i == 2) begin
        n_checks++; if (cQ_full !== 1'b0) begin n_errors++; $display("FAIL fill_cQ_full_at3: got %b want 0", cQ_full); end
      end
      if (i == 3) begin
        n_checks++; if (cQ_full !== 1'b1) begin n_errors++; $display("FAIL fill_cQ_full_at4: got %b want 1", cQ_full); end
      end
    end
    pkt_in_avail = 1'b0;
    n_checks++; if (out_count !== 3'd4) begin n_errors++; $display("FAIL fill_count_after5: got %0d want 4", out_count); end
    n_checks++; if (cQ_full !== 1'b1) begin n_errors++; $display("FAIL fill_cQ_full_after5: got %b want 1", cQ_full); end
    free_outbound = 1'b1;
    prev = 0;
    for (int p = 0; p < 4; p++) begin
      collect_tx(20, got, ok, st);
      n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL fill_pkt%0d_timeout_or_gap: got ok=%b want 1", p, ok); end
      exp = tx_exp.pop_front();
      n_checks++; if (got !== exp) begin n_errors++; $display("FAIL fill_pkt%0d: got %h want %h", p, got, exp); end
      if (p > 0) begin
        n_checks++; if (st - prev !== NFLIT + 1) begin n_errors++; $display("FAIL fill_period%0d: got %0d want %0d", p, st - prev, NFLIT + 1); end
      end
      prev = st;
      tick();
    end
    n_checks++; if (out_count !== 3'd0) begin n_errors++; $display("FAIL fill_count_drained: got %0d want 0", out_count); end
    n_checks++; if (put_outbound !== 1'b0) begin n_errors++; $display("FAIL fill_put_drained: got %b want 0", put_outbound); end
    free_outbound = 1'b0;
  endtask

  task automatic test_tx_full_push_on_pop();
    logic [31:0] exp, got;
    bit ok;
    int st;
    free_outbound = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pkt_in = 32'h5A6B7C00 | 32'(i * 3 + 8);
      pkt_in_avail = 1'b1;
      tx_exp.push_back(pkt_in);
      tick();
    end
    pkt_in_avail = 1'b0;
    free_outbound = 1'b1;
    tick();
    free_outbound = 1'b0;
    exp = tx_exp.pop_front();
    for (int k = 0; k < NFLIT; k++) begin
      n_checks++; if (payload_outbound !== exp[31-8*k -: 8]) begin n_errors++; $display("FAIL fullpop_flit%0d: got %h want %h", k, payload_outbound, exp[31-8*k -: 8]); end
      if (k == NFLIT - 1) begin
        pkt_in = 32'hBAD0BAD0;
        pkt_in_avail = 1'b1;
      end
      tick();
    end
    pkt_in_avail = 1'b0;
    n_checks++; if (out_count !== 3'd3) begin n_errors++; $display("FAIL fullpop_count: got %0d want 3", out_count); end
    n_checks++; if (cQ_full !== 1'b0) begin n_errors++; $display("FAIL fullpop_cQ_full: got %b want 0", cQ_full); end
    free_outbound = 1'b1;
    for (int p = 0; p < 3; p++) begin
      collect_tx(20, got, ok, st);
      exp = tx_exp.pop_front();
      n_checks++; if (ok !== 1'b1 || got !== exp) begin n_errors++; $display("FAIL fullpop_drain%0d: got %h ok=%b want %h", p, got, ok, exp); end
      tick();
    end
    n_checks++; if (out_count !== 3'd0) begin n_errors++; $display("FAIL fullpop_count_end: got %0d want 0", out_count); end
    free_outbound = 1'b0;
  endtask

  task automatic test_tx_push_pop_same();
    logic [31:0] exp, got;
    bit ok;
    int st;
    free_outbound = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pkt_in = 32'h3C4D5E60 | 32'(i + 1);
      pkt_in_avail = 1'b1;
      tx_exp.push_back(pkt_in);
      tick();
    end
    pkt_in_avail = 1'b0;
    free_outbound = 1'b1;
    tick();
    free_outbound = 1'b0;
    exp = tx_exp.pop_front();
    for (int k = 0; k < NFLIT; k++) begin
      n_checks++; if (payload_outbound !== exp[31-8*k -: 8]) begin n_errors++; $display("FAIL pushpop_flit%0d: got %h want %h", k, payload_outbound, exp[31-8*k -: 8]); end
      if (k == NFLIT - 1) begin
        pkt_in = 32'h99887766;
        pkt_in_avail = 1'b1;
        tx_exp.push_back(pkt_in);
      end
      tick();
    end
    pkt_in_avail = 1'b0;
    n_checks++; if (out_count !== 3'd2) begin n_errors++; $display("FAIL pushpop_count: got %0d want 2", out_count); end
    free_outbound = 1'b1;
    for (int p = 0; p < 2; p++) begin
      collect_tx(20, got, ok, st);
      exp = tx_exp.pop_front();
      n_checks++; if (ok !== 1'b1 || got !== exp) begin n_errors++; $display("FAIL pushpop_drain%0d: got %h ok=%b want %h", p, got, ok, exp); end
      tick();
    end
    n_checks++; if (out_count !== 3'd0) begin n_errors++; $display("FAIL pushpop_count_end: got %0d want 0", out_count); end
    free_outbound = 1'b0;
  endtask

  task automatic test_rx_single();
    logic [31:0] exp, v;
    v = 32'hDEADBEEF;
    rx_exp.push_back(v);
    n_checks++; if (free_inbound !== 1'b1) begin n_errors++; $display("FAIL rx1_free_before: got %b want 1", free_inbound); end
    for (int k = 0; k < NFLIT; k++) begin
      put_inbound = 1'b1;
      payload_inbound = v[31-8*k -: 8];
      tick();
      if (k == 0) begin
        n_checks++; if (free_inbound !== 1'b0) begin n_errors++; $display("FAIL rx1_free_mid: got %b want 0", free_inbound); end
      end
      if (k < NFLIT - 1) begin
        n_checks++; if (pkt_out_avail !== 1'b0) begin n_errors++; $display("FAIL rx1_avail_early%0d: got %b want 0", k, pkt_out_avail); end
      end
    end
    put_inbound = 1'b0;
    exp = rx_exp.pop_front();
    n_checks++; if (pkt_out_avail !== 1'b1) begin n_errors++; $display("FAIL rx1_avail: got %b want 1", pkt_out_avail); end
    n_checks++; if (pkt_out !== exp) begin n_errors++; $display("FAIL rx1_pkt_out: got %h want %h", pkt_out, exp); end
    n_checks++; if (in_count !== 3'd1) begin n_errors++; $display("FAIL rx1_in_count: got %0d want 1", in_count); end
    n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL rx1_proto_err: got %b want 0", proto_err); end
    pkt_out_take = 1'b1;
    tick();
    pkt_out_take = 1'b0;
    n_checks++; if (pkt_out_avail !== 1'b0 || pkt_out !== 32'h0) begin n_errors++; $display("FAIL rx1_after_take: got avail=%b pkt=%h want 0/0", pkt_out_avail, pkt_out); end
    n_checks++; if (in_count !== 3'd0) begin n_errors++; $display("FAIL rx1_count_after_take: got %0d want 0", in_count); end
  endtask

  task automatic test_rx_full();
    logic [31:0] exp, v;
    for (int i = 0; i < 4; i++) begin
      v = 32'hF1E2D300 | 32'(i * 5 + 2);
      rx_exp.push_back(v);
      send_rx(v);
    end
    n_checks++; if (free_inbound !== 1'b0) begin n_errors++; $display("FAIL rxfull_free: got %b want 0", free_inbound); end
    n_checks++; if (in_count !== 3'd4) begin n_errors++; $display("FAIL rxfull_count: got %0d want 4", in_count); end
    n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL rxfull_err_idle: got %b want 0", proto_err); end
    put_inbound = 1'b1;
    payload_inbound = 8'h77;
    tick();
    put_inbound = 1'b0;
    n_checks++; if (proto_err !== 1'b1) begin n_errors++; $display("FAIL rxfull_err_pulse: got %b want 1", proto_err); end
    n_checks++; if (in_count !== 3'd4) begin n_errors++; $display("FAIL rxfull_count_after_put: got %0d want 4", in_count); end
    tick();
    n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL rxfull_err_one_cycle: got %b want 0", proto_err); end
    exp = rx_exp.pop_front();
    n_checks++; if (pkt_out !== exp) begin n_errors++; $display("FAIL rxfull_head0: got %h want %h", pkt_out, exp); end
    pkt_out_take = 1'b1;
    tick();
    pkt_out_take = 1'b0;
    n_checks++; if (free_inbound !== 1'b1) begin n_errors++; $display("FAIL rxfull_free_after_take: got %b want 1", free_inbound); end
    n_checks++; if (in_count !== 3'd3) begin n_errors++; $display("FAIL rxfull_count_after_take: got %0d want 3", in_count); end
    for (int i = 0; i < 3; i++) begin
      exp = rx_exp.pop_front();
      n_checks++; if (pkt_out !== exp) begin n_errors++; $display("FAIL rxfull_head%0d: got %h want %h", i + 1, pkt_out, exp); end
      pkt_out_take = 1'b1;
      tick();
      pkt_out_take = 1'b0;
    end
    n_checks++; if (pkt_out_avail !== 1'b0 || in_count !== 3'd0) begin n_errors++; $display("FAIL rxfull_drained: got avail=%b count=%0d want 0/0", pkt_out_avail, in_count); end
  endtask

  task automatic test_rx_abort();
    logic [31:0] exp, v;
    put_inbound = 1'b1;
    payload_inbound = 8'h11;
    tick();
    payload_inbound = 8'h22;
    tick();
    put_inbound = 1'b0;
    tick();
    n_checks++; if (proto_err !== 1'b1) begin n_errors++; $display("FAIL abort_err_pulse: got %b want 1", proto_err); end
    n_checks++; if (in_count !== 3'd0 || pkt_out_avail !== 1'b0) begin n_errors++; $display("FAIL abort_no_push: got count=%0d avail=%b want 0/0", in_count, pkt_out_avail); end
    tick();
    n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL abort_err_one_cycle: got %b want 0", proto_err); end
    n_checks++; if (free_inbound !== 1'b1) begin n_errors++; $display("FAIL abort_free: got %b want 1", free_inbound); end
    v = 32'h0BADF00D;
    rx_exp.push_back(v);
    send_rx(v);
    exp = rx_exp.pop_front();
    n_checks++; if (pkt_out !== exp || pkt_out_avail !== 1'b1) begin n_errors++; $display("FAIL abort_next_pkt: got %h avail=%b want %h", pkt_out, pkt_out_avail, exp); end
    n_checks++; if (in_count !== 3'd1) begin n_errors++; $display("FAIL abort_next_count: got %0d want 1", in_count); end
    pkt_out_take = 1'b1;
    tick();
    pkt_out_take = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] exp, v;
    v = 32'h13579BDF;
    free_outbound = 1'b1;
    pkt_in = v;
    pkt_in_avail = 1'b1;
    tick();
    pkt_in_avail = 1'b0;
    tick();
    put_inbound = 1'b1;
    payload_inbound = 8'hAA;
    tick();
    tick();
    n_checks++; if (put_outbound !== 1'b1 || payload_outbound !== v[15:8]) begin n_errors++; $display("FAIL rstmid_flit2: got put=%b %h want 1 %h", put_outbound, payload_outbound, v[15:8]); end
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    put_inbound = 1'b0;
    payload_inbound = '0;
    n_checks++; if (put_outbound !== 1'b0 || payload_outbound !== 8'h00) begin n_errors++; $display("FAIL rstmid_put: got put=%b %h want 0 00", put_outbound, payload_outbound); end
    n_checks++; if (out_count !== 3'd0) begin n_errors++; $display("FAIL rstmid_out_count: got %0d want 0", out_count); end
    n_checks++; if (free_inbound !== 1'b1) begin n_errors++; $display("FAIL rstmid_free_inbound: got %b want 1", free_inbound); end
    n_checks++; if (in_count !== 3'd0 || proto_err !== 1'b0) begin n_errors++; $display("FAIL rstmid_rx: got count=%0d err=%b want 0/0", in_count, proto_err); end
    tick();
    n_checks++; if (proto_err !== 1'b0 || put_outbound !== 1'b0) begin n_errors++; $display("FAIL rstmid_quiet: got err=%b put=%b want 0/0", proto_err, put_outbound); end
    free_outbound = 1'b0;
    v = 32'h2468ACE1;
    rx_exp.push_back(v);
    send_rx(v);
    exp = rx_exp.pop_front();
    n_checks++; if (pkt_out !== exp) begin n_errors++; $display("FAIL rstmid_rx_after: got %h want %h", pkt_out, exp); end
  endtask

  initial begin
    rst_b = 1'b0;
    pkt_in = '0;
    pkt_in_avail = 1'b0;
    free_outbound = 1'b0;
    put_inbound = 1'b0;
    payload_inbound = '0;
    pkt_out_take = 1'b0;
    test_reset();
    test_tx_single();
    test_tx_fill_drop();
    test_tx_full_push_on_pop();
    test_tx_push_pop_same();
    test_rx_single();
    test_rx_full();
    test_rx_abort();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/link_endpoint.md
# link_endpoint

- Parametrised network endpoint that sits between the testbench-facing packet interface and one router port.
- Outbound path: buffers whole packets in a FIFO, then serialises each into `PKT_W/FLIT_W` flits over the free/put handshake.
- Inbound path: deserialises flits from the router into a second FIFO, drained by a valid/take interface.
- New over the previous node generation: configurable widths and depths, simultaneous push/pop, inbound backpressure, and protocol-error detection.

## Interface
- `PKT_W`, 32, packet width in bits.
- `FLIT_W`, 8, flit width in bits; `NFLIT = PKT_W/FLIT_W`, integer, ≥ 2.
- `OUT_DEPTH`, 4, outbound FIFO depth, ≥ 2, any value.
- `IN_DEPTH`, 4, inbound FIFO depth, ≥ 2, any value.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_b`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `pkt_in`  in  PKT_W  packet to enqueue.
- `pkt_in_avail`  in  1  enqueue request.
- `cQ_full`  out  1  outbound FIFO holds `OUT_DEPTH` packets.
- `out_count`  out  $clog2(OUT_DEPTH+1)  outbound occupancy.
- `free_outbound`  in  1  router ready to accept a packet.
- `put_outbound`  out  1  flit valid to router.
- `payload_outbound`  out  FLIT_W  outbound flit.
- `free_inbound`  out  1  endpoint ready to accept a packet.
- `put_inbound`  in  1  flit valid from router.
- `payload_inbound`  in  FLIT_W  inbound flit.
- `pkt_out`  out  PKT_W  head of inbound FIFO; 0 when empty.
- `pkt_out_avail`  out  1  inbound FIFO non-empty.
- `pkt_out_take`  in  1  pop inbound head.
- `in_count`  out  $clog2(IN_DEPTH+1)  inbound occupancy.
- `proto_err`  out  1  one-cycle pulse on a handshake violation.

## Operation
- **Flit order:** MSB first. Flit k = `pkt[PKT_W-1-k*FLIT_W -: FLIT_W]`.
- **FIFOs:** circular buffers; pointers wrap from DEPTH-1 to 0.
  - Push when request is high and FIFO is not full. Pop when request is high and FIFO is not empty. Full/empty are evaluated on pre-edge state.
  - Push and pop in the same cycle both take effect; count is unchanged.
  - A push while full is dropped silently. A pop while empty is ignored.
- **TX FSM** (states `TX_IDLE`, `TX_SEND`; flit index `tidx`):
  - `TX_IDLE`: `put_outbound=0`, `payload_outbound=0`. If the out FIFO is non-empty and `free_outbound=1`, go to `TX_SEND` with `tidx=0`.
  - `TX_SEND`: `put_outbound=1`, `payload_outbound` = flit[`tidx`] of the FIFO head; `tidx` increments each cycle. `free_outbound` is ignored.
  - At the edge ending flit NFLIT-1: pop the out FIFO and return to `TX_IDLE`.
- **RX FSM** (states `RX_IDLE`, `RX_RECV`; shift register plus index `ridx`):
  - `RX_IDLE`: `free_inbound` = in FIFO not full.
    - `put_inbound=1` and `free_inbound=1`: capture flit 0, go to `RX_RECV` with `ridx=1`.
    - `put_inbound=1` and `free_inbound=0`: flit ignored, `proto_err` pulses.
  - `RX_RECV`: `free_inbound=0`. On each `put_inbound=1`, capture a flit and increment `ridx`.
    - After flit NFLIT-1 is captured: push the assembled packet and return to `RX_IDLE`.
    - `put_inbound=0` mid-packet: discard the partial packet, pulse `proto_err`, return to `RX_IDLE`.
- **Inbound space guarantee:** only the RX FSM pushes the in FIFO, so space checked at packet start is guaranteed at packet end.
- **Reset** (any cycle, including mid-packet):
  - Both FSMs go to idle; both FIFOs are emptied; any partial packet is discarded.
  - Outputs after the reset edge: `put_outbound=0`, `payload_outbound=0`, `free_inbound=1`, `cQ_full=0`, `out_count=0`, `pkt_out=0`, `pkt_out_avail=0`, `in_count=0`, `proto_err=0`.

## Timing
- **TX latency:** `pkt_in_avail` sampled at edge E0 with the out FIFO empty and `free_outbound=1` in the next cycle → FSM enters `TX_SEND` at E1.
  - Flits appear in NFLIT consecutive cycles after E1, with `put_outbound` high throughout.
  - `out_count` decrements at edge E1+NFLIT.
- **TX back-to-back:** at least one `TX_IDLE` cycle between packets, so the minimum packet period is NFLIT+1 cycles.
- **RX latency:** last flit sampled at edge Ek → `pkt_out_avail=1` and `pkt_out` valid in the cycle after Ek (if the FIFO was empty).
  - A push at Ek that makes the in FIFO full → `free_inbound=0` from the cycle after Ek.
- **`proto_err`:** asserted in the cycle following the offending edge, for exactly one cycle.
- **`cQ_full` / counts:** registered-state derived; they update in the cycle after the causing edge.
- **`payload_outbound`** is 0 whenever `put_outbound=0`.

## Test plan
- Defaults, `free_outbound=1`: push 0xA5123456 → `put_outbound` high for 4 cycles carrying A5,12,34,56, starting 2 edges after the push; `out_count` 1→0.
- Push 5 packets on back-to-back cycles with `free_outbound=0` → `cQ_full=1` after 4 pushes, 5th dropped, `out_count=4`. Then raise `free_outbound` → exactly the 4 accepted packets are sent in order, with 1 idle cycle between packets.
- Out FIFO full while TX finishes a packet, with a push on the same edge as the pop → push dropped, `out_count` goes 4→3.
- With 2 packets queued and TX popping, a push in the pop cycle → both take effect, `out_count` unchanged.
- Drive flits DE,AD,BE,EF with `put_inbound` held 4 cycles → `pkt_out=0xDEADBEEF`, `pkt_out_avail=1` one cycle after the last flit.
- Fill the in FIFO (4 packets, no take) → `free_inbound=0`; a further put → `proto_err` pulse, `in_count` stays 4. Take once → `free_inbound=1` next cycle.
- Drop `put_inbound` after 2 flits → `proto_err` pulse, no push. A following full packet is received correctly.
- Assert `rst_b=0` during `TX_SEND` flit 2 → next cycle `put_outbound=0`, `out_count=0`, `free_inbound=1`.
